// File: rtl/sort_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sort_step_ctrl
// Purpose  : Step-command generator in front of the bubble sort engine.
//            Synchronises and debounces the three push buttons, keeps the
//            pause state, produces timed auto-advance pulses while running,
//            and produces single / auto-repeating forward and back step
//            pulses while paused.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   system clock, all state on posedge
//   rst_n      in   asynchronous active-low reset
//   btnC       in   raw button, pause/continue toggle
//   btnR       in   raw button, step forward
//   btnL       in   raw button, step back
//   run        in   sort enable level, synchronous to clk
//   done       in   sort-complete flag from the engine
//   step_fwd   out  one-cycle pulse, engine performs one compare/swap step
//   step_back  out  one-cycle pulse, engine moves back one step
//   paused     out  registered pause state
// ============================================================================
module sort_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP_PERIOD     = 100_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btnC,
  input  logic btnR,
  input  logic btnL,
  input  logic run,
  input  logic done,
  output logic step_fwd,
  output logic step_back,
  output logic paused
);

  // --------------------------------------------------------------------------
  // Counter widths
  // --------------------------------------------------------------------------
  localparam int C_DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int C_PER_W  = $clog2(STEP_PERIOD);
  localparam int C_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int C_RPT_W  = $clog2(C_RPT_MAX);

  // Button index map shared by the debounce and repeat logic.
  localparam int C_BTN_C = 0;
  localparam int C_BTN_R = 1;
  localparam int C_BTN_L = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  // --------------------------------------------------------------------------
  // Shared signals
  // --------------------------------------------------------------------------
  logic [2:0] w_btn_raw;
  logic [2:0] w_press;     // one-cycle press events, one per button
  logic [2:1] w_stable;    // debounced levels of the step buttons
  logic [1:0] w_rpt_pulse; // [0] forward FSM, [1] back FSM
  logic [1:0] w_rpt_idle;

  logic                r_paused;
  logic                r_step_fwd;
  logic                r_step_back;
  logic [C_PER_W-1:0]  r_per_cnt;

  logic w_auto;
  logic w_auto_hit;

  assign w_btn_raw = {btnL, btnR, btnC};

  // --------------------------------------------------------------------------
  // Synchroniser + debounce + press detect, one slice per button
  // --------------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_db
    logic              r_sync1;
    logic              r_sync2;
    logic              r_stable;
    logic              r_stable_d;
    logic [C_DB_W-1:0] r_db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1    <= 1'b0;
        r_sync2    <= 1'b0;
        r_stable   <= 1'b0;
        r_stable_d <= 1'b0;
        r_db_cnt   <= '0;
      end else begin
        r_sync1    <= w_btn_raw[gi];
        r_sync2    <= r_sync1;
        r_stable_d <= r_stable;
        // The stable level only flips after DEBOUNCE_CYCLES consecutive
        // disagreeing samples; any agreeing sample restarts the count.
        if (r_sync2 == r_stable) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == C_DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_stable <= ~r_stable;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end
    end

    // Rising edge of the debounced level only; releases are not events.
    assign w_press[gi] = r_stable & ~r_stable_d;

    if (gi != C_BTN_C) begin : g_stable_out
      assign w_stable[gi] = r_stable;
    end
  end

  // --------------------------------------------------------------------------
  // Repeat FSMs: index 0 drives step_fwd from btnR, index 1 drives step_back
  // from btnL.
  // --------------------------------------------------------------------------
  genvar gk;
  for (gk = 0; gk < 2; gk++) begin : g_rpt
    localparam int C_OWN   = gk + 1;  // own button index
    localparam int C_OTHER = 2 - gk;  // other step button index
    localparam int C_OFSM  = 1 - gk;  // other FSM index

    rpt_state_t         r_state;
    logic [C_RPT_W-1:0] r_cnt;
    logic               w_keep;
    logic               w_start;
    logic               w_hit_delay;
    logic               w_hit_period;
    logic               w_pulse;

    // Held and still in manual mode.
    assign w_keep = r_paused & w_stable[C_OWN];

    // A press starts a sequence only while paused, only if the other button
    // did not press in the same cycle, and only if the other FSM is idle.
    assign w_start = r_paused & w_press[C_OWN] & ~w_press[C_OTHER] & w_rpt_idle[C_OFSM];

    assign w_hit_delay  = (r_cnt == C_RPT_W'(REPEAT_DELAY - 1));
    assign w_hit_period = (r_cnt == C_RPT_W'(REPEAT_PERIOD - 1));

    always_comb begin
      w_pulse = 1'b0;
      case (r_state)
        ST_IDLE:   w_pulse = w_start;
        ST_HOLD:   w_pulse = w_keep & w_hit_delay;
        ST_REPEAT: w_pulse = w_keep & w_hit_period;
        default:   w_pulse = 1'b0;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            if (w_start) begin
              r_state <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (!w_keep) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else if (w_hit_delay) begin
              r_state <= ST_REPEAT;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (!w_keep) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else if (w_hit_period) begin
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    assign w_rpt_pulse[gk] = w_pulse;
    assign w_rpt_idle[gk]  = (r_state == ST_IDLE);
  end

  // --------------------------------------------------------------------------
  // Pause state, auto-advance timer and registered outputs.
  // All step sources look at r_paused before any toggle this cycle.
  // --------------------------------------------------------------------------
  assign w_auto     = run & ~r_paused & ~done;
  assign w_auto_hit = w_auto & (r_per_cnt == C_PER_W'(STEP_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_paused    <= 1'b0;
      r_per_cnt   <= '0;
      r_step_fwd  <= 1'b0;
      r_step_back <= 1'b0;
    end else begin
      if (!run) begin
        r_paused <= 1'b0;
      end else if (w_press[C_BTN_C]) begin
        r_paused <= ~r_paused;
      end

      // Held at zero outside auto mode so entry always waits a full period.
      if (!w_auto || w_auto_hit) begin
        r_per_cnt <= '0;
      end else begin
        r_per_cnt <= r_per_cnt + 1'b1;
      end

      // Auto mode needs r_paused=0 and the FSMs only start with r_paused=1,
      // and the two FSMs never run together, so the outputs are exclusive.
      r_step_fwd  <= (w_auto_hit | w_rpt_pulse[0]) & ~done;
      r_step_back <= w_rpt_pulse[1];
    end
  end

  assign step_fwd  = r_step_fwd;
  assign step_back = r_step_back;
  assign paused    = r_paused;

endmodule
`default_nettype wire

// File: tb/tb_sort_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_step_ctrl
// Purpose  : Self-checking bench for sort_step_ctrl with a timestamp-based
//            reference model, directed scenarios and randomised button
//            activity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sort_step_ctrl;

  localparam int DC = 4;
  localparam int SP = 10;
  localparam int RD = 20;
  localparam int RP = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btnC  = 1'b0;
  logic btnR  = 1'b0;
  logic btnL  = 1'b0;
  logic run   = 1'b1;
  logic done  = 1'b0;
  logic step_fwd;
  logic step_back;
  logic paused;

  int n_tests = 0;
  int n_fail  = 0;
  int nfwd    = 0;
  int nback   = 0;

  always #5 clk = ~clk;

  sort_step_ctrl #(
    .DEBOUNCE_CYCLES (DC),
    .STEP_PERIOD     (SP),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btnC      (btnC),
    .btnR      (btnR),
    .btnL      (btnL),
    .run       (run),
    .done      (done),
    .step_fwd  (step_fwd),
    .step_back (step_back),
    .paused    (paused)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. Time is the count of active clock edges (m_n); button
  // flips, auto pulses and repeat pulses are derived from elapsed edge
  // counts since the relevant event.
  // --------------------------------------------------------------------------
  bit m_s1[3], m_s2[3], m_stab[3], m_press[3];
  int m_agree[3];       // last edge at which sync level agreed with stable
  bit m_paused, m_fwd, m_back;
  int m_n = 0;
  int m_auto_entry;     // last edge at which auto mode was inactive
  bit m_held[2];        // 0: forward (btnR), 1: back (btnL)
  int m_t0[2];          // edge of the initial manual pulse

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_stab[b] = 0; m_press[b] = 0;
      m_agree[b] = m_n;
    end
    m_paused = 0; m_fwd = 0; m_back = 0;
    m_auto_entry = m_n;
    for (int x = 0; x < 2; x++) begin
      m_held[x] = 0; m_t0[x] = 0;
    end
  endtask

  task automatic model_step();
    bit raw[3], p_old[3], s_old[3], h_old[2], pulse[2];
    bit pz_old, auto_p;
    int d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_n++;
    raw[0] = btnC; raw[1] = btnR; raw[2] = btnL;
    for (int b = 0; b < 3; b++) begin
      p_old[b] = m_press[b];
      s_old[b] = m_stab[b];
    end
    pz_old = m_paused;
    h_old[0] = m_held[0]; h_old[1] = m_held[1];

    for (int b = 0; b < 3; b++) begin
      if (m_s2[b] == m_stab[b]) begin
        m_agree[b] = m_n;
      end else if (m_n - m_agree[b] >= DC) begin
        m_stab[b]  = ~m_stab[b];
        m_agree[b] = m_n;
      end
      m_press[b] = m_stab[b] & ~s_old[b];
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end

    m_paused = run ? (p_old[0] ? ~pz_old : pz_old) : 1'b0;

    auto_p = 0;
    if (run && !pz_old && !done) begin
      auto_p = ((m_n - m_auto_entry) % SP) == 0;
    end else begin
      m_auto_entry = m_n;
    end

    for (int x = 0; x < 2; x++) begin
      pulse[x] = 0;
      if (h_old[x]) begin
        if (!pz_old || !s_old[x + 1]) begin
          m_held[x] = 0;
        end else begin
          d = m_n - m_t0[x];
          pulse[x] = (d == RD) || (d > RD && ((d - RD) % RP) == 0);
        end
      end else if (pz_old && p_old[x + 1] && !p_old[2 - x] && !h_old[1 - x]) begin
        m_held[x] = 1;
        m_t0[x]   = m_n;
        pulse[x]  = 1;
      end
    end

    m_fwd  = (auto_p | pulse[0]) & ~done;
    m_back = pulse[1];
  endtask

  // One clock: update the model at the active edge, compare on the falling
  // edge, and keep running pulse counts for the directed checks.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("fwd", step_fwd, m_fwd);
    check("back", step_back, m_back);
    check("paused", paused, m_paused);
    check("excl", step_fwd & step_back, 0);
    if (step_fwd === 1'b1)  nfwd++;
    if (step_back === 1'b1) nback++;
  endtask

  initial begin
    int first, nf, nb, cnt, late;
    int times[16];
    int hold[3];

    model_reset();
    repeat (3) tick();
    check("rst_fwd", step_fwd, 0);
    check("rst_back", step_back, 0);
    check("rst_paused", paused, 0);

    // Auto mode straight out of reset.
    rst_n = 1'b1;
    nf = nfwd; first = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (step_fwd === 1'b1 && first < 0) first = i;
    end
    check("auto_first", first, 10);
    check("auto_cnt", nfwd - nf, 5);

    // btnC held: press sampled on tick 1, paused visible on tick 7.
    btnC = 1'b1;
    repeat (6) tick();
    check("pause_early", paused, 0);
    tick();
    check("pause_set", paused, 1);
    repeat (5) tick();
    btnC = 1'b0;
    repeat (10) tick();
    nf = nfwd;
    btnC = 1'b1;
    repeat (3) tick();
    btnC = 1'b0;
    repeat (12) tick();
    check("glitch_paused", paused, 1);
    check("glitch_noauto", nfwd - nf, 0);

    // Clean 10-cycle tap on btnR.
    nf = nfwd; first = -1;
    btnR = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 10) btnR = 1'b0;
      if (step_fwd === 1'b1 && first < 0) first = i;
    end
    check("tap_lat", first, 7);
    check("tap_cnt", nfwd - nf, 1);

    // Same tap with done asserted.
    done = 1'b1;
    nf = nfwd;
    btnR = 1'b1;
    repeat (10) tick();
    btnR = 1'b0;
    repeat (15) tick();
    done = 1'b0;
    check("tap_done", nfwd - nf, 0);

    // btnL held for 50 cycles.
    cnt = 0; late = 0;
    btnL = 1'b1;
    for (int i = 1; i <= 75; i++) begin
      tick();
      if (i == 50) btnL = 1'b0;
      if (step_back === 1'b1) begin
        if (cnt < 16) times[cnt] = i;
        cnt++;
        if (i >= 53) late++;
      end
    end
    check("rep_p0", times[0], 7);
    check("rep_p1", times[1], 27);
    check("rep_p2", times[2], 32);
    check("rep_p3", times[3], 37);
    check("rep_after_rel", late, 0);

    // Both step buttons raised together.
    nf = nfwd; nb = nback;
    btnR = 1'b1; btnL = 1'b1;
    repeat (40) tick();
    btnR = 1'b0; btnL = 1'b0;
    repeat (15) tick();
    check("both_fwd", nfwd - nf, 0);
    check("both_back", nback - nb, 0);

    // Asynchronous reset right after the first repeat pulse.
    btnR = 1'b1;
    repeat (27) tick();
    check("pre_rst_fwd", step_fwd, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_fwd", step_fwd, 0);
    check("arst_back", step_back, 0);
    check("arst_paused", paused, 0);
    btnR = 1'b0;
    nf = nfwd;
    repeat (3) tick();
    check("arst_hold", nfwd - nf, 0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Pause again, start a repeat, then drop run.
    btnC = 1'b1;
    repeat (8) tick();
    btnC = 1'b0;
    repeat (8) tick();
    check("repause", paused, 1);
    btnR = 1'b1;
    repeat (32) tick();
    run = 1'b0;
    tick();
    check("run_drop", paused, 0);
    nf = nfwd;
    repeat (20) tick();
    check("run_stop", nfwd - nf, 0);
    btnR = 1'b0;
    run  = 1'b1;
    repeat (10) tick();

    // Randomised button activity with bounce, run/done changes and the
    // occasional asynchronous reset.
    for (int b = 0; b < 3; b++) hold[b] = $urandom_range(1, 35);
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          case (b)
            0:       btnC = ~btnC;
            1:       btnR = ~btnR;
            default: btnL = ~btnL;
          endcase
          hold[b] = $urandom_range(1, 35);
        end else begin
          hold[b]--;
        end
      end
      if ($urandom_range(0, 299) == 0) run  = ~run;
      if ($urandom_range(0, 149) == 0) done = ~done;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rnd_arst", {29'd0, step_fwd, step_back, paused}, 0);
        tick();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sort_step_ctrl.md
# sort_step_ctrl

Control stage directly upstream of the bubble sort engine. It turns raw push-button and switch levels into clean one-cycle step commands. It synchronises and debounces btnC/btnR/btnL, holds the pause state, and generates timed auto-advance pulses while running. While paused it generates single or auto-repeating forward/back step pulses. The sort engine consumes `step_fwd`/`step_back`/`paused` and no longer needs its own delay counter or edge detection.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive cycles a synchronised button must differ from its stable value before the stable value flips (10 ms at 100 MHz); ≥2.
- STEP_PERIOD, 100_000_000: cycles between auto-advance pulses while running; ≥2.
- REPEAT_DELAY, 50_000_000: hold time after the first manual step before auto-repeat starts; ≥2.
- REPEAT_PERIOD, 10_000_000: cycles between auto-repeat pulses; ≥2.

Ports:
- clk  in  1  100 MHz system clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- btnC  in  1  raw button, pause/continue toggle.
- btnR  in  1  raw button, step forward.
- btnL  in  1  raw button, step back.
- run  in  1  sort enable (sw1 level); already synchronous to clk.
- done  in  1  sort-complete flag from the engine.
- step_fwd  out  1  one-cycle pulse: engine performs one compare/swap step.
- step_back  out  1  one-cycle pulse: engine moves back one step.
- paused  out  1  registered pause state.

## Operation
- Synchroniser: two flops per button; reset value 0.
- Debounce, one per button:
  - The counter clears whenever the synchronised value equals the stable value.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the stable value flips and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- Press event: one-cycle pulse on each 0→1 transition of a stable value. Releases generate no event.
- Pause:
  - `paused` toggles on a btnC press.
  - It clears when `run`=0, and stays 0 while `run`=0.
- Auto mode (run=1, paused=0, done=0):
  - The period counter counts 0..STEP_PERIOD-1 and wraps.
  - `step_fwd` asserts in the cycle after the counter equals STEP_PERIOD-1.
  - The period counter holds at 0 whenever auto mode is inactive, so the first auto step comes a full STEP_PERIOD after entry.
- Manual mode (paused=1): btnR and btnL each have a repeat FSM with states IDLE, HOLD and REPEAT.
  - IDLE→HOLD on a press event. This emits one step pulse and clears the repeat counter.
  - HOLD→REPEAT when the counter reaches REPEAT_DELAY-1 with the stable value still 1. This emits a pulse and clears the counter.
  - In REPEAT, a pulse is emitted each time the counter reaches REPEAT_PERIOD-1, then the counter clears.
  - HOLD or REPEAT→IDLE when the stable value goes to 0, or when `paused` goes to 0.
- btnR vs btnL:
  - If both press events occur in the same cycle, both are ignored and both FSMs stay in IDLE.
  - While one FSM is in HOLD or REPEAT, press events on the other button are ignored.
- `done`=1 suppresses every `step_fwd` source (auto, manual and repeat). `step_back` is still allowed while paused.
- btnC press coinciding with a step source: the step is gated by the `paused` value before the toggle.
- `step_fwd` and `step_back` are never high in the same cycle.

## Timing
- Reset (rst_n=0, async) clears all of the following immediately:
  - `step_fwd`, `step_back` and `paused`
  - synchroniser and stable values
  - all counters
  - both FSMs to IDLE
- Release of rst_n is assumed synchronous to clk upstream.
- All outputs are registered; no combinational path from any input to any output.
- Button latency: raw rising edge at cycle t (held clean) → stable value flips in cycle t+1+DEBOUNCE_CYCLES → press event → output pulse in cycle t+2+DEBOUNCE_CYCLES (`paused` toggles in the same cycle).
- Bounce shorter than DEBOUNCE_CYCLES consecutive cycles produces no event.
- Auto pulses are spaced exactly STEP_PERIOD cycles apart.
- Repeat:
  - The first repeat pulse comes REPEAT_DELAY cycles after the initial manual pulse.
  - Subsequent pulses are REPEAT_PERIOD cycles apart.
- Reset mid-hold or mid-period: no pulse is emitted after rst_n falls. On release, counting restarts from 0.

## Test plan
Test parameters: DEBOUNCE_CYCLES=4, STEP_PERIOD=10, REPEAT_DELAY=20, REPEAT_PERIOD=5.
- Reset with run=1 and all buttons low, then release rst_n → first `step_fwd` 10 cycles after release, then every 10 cycles; `paused`=0 throughout; exactly 5 pulses in 50 cycles.
- btnC held high from cycle t → `paused`=1 at t+6. Then a btnC glitch lasting 3 cycles → `paused` unchanged and no auto pulses.
- Paused, btnR clean tap of 10 cycles → exactly one `step_fwd`, 6 cycles after press. Same with done=1 → no pulse.
- Paused, btnL held 50 cycles → first `step_back` at press+6, then at +20, +25 and +30 from that first pulse, with no further pulses once the stable value falls.
- Paused, btnR and btnL raised in the same cycle → no pulses.
- During btnR repeat: assert rst_n=0 → outputs 0 immediately and no further pulses. Separately, drop `run` while paused → `paused`=0 next cycle and the repeat stops.
